// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the tagged main-memory bus arbiter.
//   ADDR_W_DEF  default word-address width (1M words)
//   DATA_W      bus data width
//   TAG_W       bus tag width
//   mem_state_t bus sequencer states
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned TAG_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ,
    RDLAT,
    WRITE,
    DONE
  } mem_state_t;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-requester arbiter.
//   req0, req1  request lines
//   last        index of the most recent grant (round-robin pointer)
//   gnt_valid   at least one request present
//   gnt_idx     index of the winning requester
//   FIXED_PRIO  1 = requester 0 wins every tie, 0 = tie goes to !last
module arb_rr2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = 1'b0;
    if (req0 && req1) begin
      gnt_idx = FIXED_PRIO ? 1'b0 : ~last;
    end else begin
      gnt_idx = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and sequencer for the tagged main-memory bus.
//   clk, reset              system clock, synchronous active-high reset
//   mN_req/we/addr/wdata/wtag  port N request (held until mN_ack)
//   mN_ack                  one-cycle completion pulse
//   mN_rdata/mN_rtag        last read data/tag returned to port N
//   o_ad/o_tag              multiplexed bus address/data and write tag
//   o_astb/o_rd/o_wr        address, read and write strobes
//   i_data/i_tag            RAM read data and tag
// One transaction in flight; write = 4 cycles, read = 5 cycles incl. IDLE.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [TAG_W-1:0]  m0_wtag,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [TAG_W-1:0]  m0_rtag,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [TAG_W-1:0]  m1_wtag,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [TAG_W-1:0]  m1_rtag,

  output logic [DATA_W-1:0] o_ad,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_astb,
  output logic              o_rd,
  output logic              o_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag
);

  mem_state_t        state;
  logic              last;
  logic              gnt;
  logic              t_we;
  logic [DATA_W-1:0] t_wdata;
  logic [TAG_W-1:0]  t_wtag;

  logic              gnt_valid;
  logic              gnt_idx;
  logic [ADDR_W-1:0] win_addr;

  arb_rr2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .req0      (m0_req),
    .req1      (m1_req),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign win_addr = gnt_idx ? m1_addr : m0_addr;

  // Bus outputs and acks are registered one state ahead, so each is a
  // clean flop output during the state it belongs to. The address only
  // appears on the bus during ADDR, so it needs no transaction latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      t_we     <= 1'b0;
      t_wdata  <= '0;
      t_wtag   <= '0;
      o_ad     <= '0;
      o_tag    <= '0;
      o_astb   <= 1'b0;
      o_rd     <= 1'b0;
      o_wr     <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m0_rtag  <= '0;
      m1_rdata <= '0;
      m1_rtag  <= '0;
    end else begin
      o_ad   <= '0;
      o_tag  <= '0;
      o_astb <= 1'b0;
      o_rd   <= 1'b0;
      o_wr   <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;

      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            gnt     <= gnt_idx;
            last    <= gnt_idx;
            t_we    <= gnt_idx ? m1_we    : m0_we;
            t_wdata <= gnt_idx ? m1_wdata : m0_wdata;
            t_wtag  <= gnt_idx ? m1_wtag  : m0_wtag;
            o_astb  <= 1'b1;
            o_ad    <= DATA_W'(win_addr);
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (t_we) begin
            o_wr  <= 1'b1;
            o_ad  <= t_wdata;
            o_tag <= t_wtag;
            state <= WRITE;
          end else begin
            o_rd  <= 1'b1;
            state <= READ;
          end
        end
        WRITE: begin
          m0_ack <= ~gnt;
          m1_ack <= gnt;
          state  <= DONE;
        end
        READ: begin
          state <= RDLAT;
        end
        RDLAT: begin
          if (gnt) begin
            m1_rdata <= i_data;
            m1_rtag  <= i_tag;
          end else begin
            m0_rdata <= i_data;
            m0_rtag  <= i_tag;
          end
          m0_ack <= ~gnt;
          m1_ack <= gnt;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [19:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic [7:0]  m0_wtag, m1_wtag;
  logic        m0_ack, m1_ack;
  logic [63:0] m0_rdata, m1_rdata;
  logic [7:0]  m0_rtag, m1_rtag;
  logic [63:0] o_ad;
  logic [7:0]  o_tag;
  logic        o_astb, o_rd, o_wr;
  logic [63:0] i_data;
  logic [7:0]  i_tag;

  // fixed-priority instance (shares requester inputs, no RAM attached)
  logic        f_m0_ack, f_m1_ack;
  logic [63:0] f_m0_rdata, f_m1_rdata, f_o_ad;
  logic [7:0]  f_m0_rtag, f_m1_rtag, f_o_tag;
  logic        f_o_astb, f_o_rd, f_o_wr;
  logic [63:0] f_i_data = '0;
  logic [7:0]  f_i_tag  = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(20), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wtag(m0_wtag),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rtag(m0_rtag),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wtag(m1_wtag),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rtag(m1_rtag),
    .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb), .o_rd(o_rd), .o_wr(o_wr),
    .i_data(i_data), .i_tag(i_tag)
  );

  mem_arbiter #(.ADDR_W(20), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wtag(m0_wtag),
    .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata), .m0_rtag(f_m0_rtag),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wtag(m1_wtag),
    .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata), .m1_rtag(f_m1_rtag),
    .o_ad(f_o_ad), .o_tag(f_o_tag), .o_astb(f_o_astb), .o_rd(f_o_rd), .o_wr(f_o_wr),
    .i_data(f_i_data), .i_tag(f_i_tag)
  );

  // RAM model: address latched on astb, write commits / read loads at the
  // edge ending the strobe cycle.
  logic [71:0] mem [0:(1<<20)-1];
  logic [19:0] ram_addr = '0;

  always @(posedge clk) begin
    if (o_astb) ram_addr <= o_ad[19:0];
    if (o_wr)   mem[ram_addr] <= {o_tag, o_ad};
    if (o_rd)   {i_tag, i_data} <= mem[ram_addr];
  end

  // Protocol monitors
  logic astb_seen = 1'b0, wait0 = 1'b0, wait1 = 1'b0;

  always @(posedge clk) begin
    assert ($onehot0({o_astb, o_rd, o_wr}))
      else begin errors++; $display("FAIL strobe_excl: astb=%b rd=%b wr=%b", o_astb, o_rd, o_wr); end
    assert ($onehot0({f_o_astb, f_o_rd, f_o_wr}))
      else begin errors++; $display("FAIL strobe_excl_fp: astb=%b rd=%b wr=%b", f_o_astb, f_o_rd, f_o_wr); end
    if (reset) begin
      astb_seen <= 1'b0;
      wait0     <= 1'b0;
      wait1     <= 1'b0;
    end else begin
      if (o_astb) astb_seen <= 1'b1;
      if (m0_ack) begin
        assert (astb_seen && wait0 && !m1_ack)
          else begin errors++; $display("FAIL ack0_no_grant: seen=%b wait=%b ack1=%b", astb_seen, wait0, m1_ack); end
        astb_seen <= 1'b0;
        wait0     <= 1'b0;
      end else if (wait0 && !m0_req) begin
        errors++; $display("FAIL req0_drop: req=0 required 1 until ack");
      end else if (m0_req) wait0 <= 1'b1;
      if (m1_ack) begin
        assert (astb_seen && wait1)
          else begin errors++; $display("FAIL ack1_no_grant: seen=%b wait=%b", astb_seen, wait1); end
        astb_seen <= 1'b0;
        wait1     <= 1'b0;
      end else if (wait1 && !m1_req) begin
        errors++; $display("FAIL req1_drop: req=0 required 1 until ack");
      end else if (m1_req) wait1 <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected read registers per port
  logic [63:0] exp_rd [2];
  logic [7:0]  exp_rt [2];

  // Runs one transaction starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic txn(input bit p, input bit we, input logic [19:0] a,
                     input logic [63:0] d, input logic [7:0] t,
                     input logic [63:0] ed, input logic [7:0] et);
    bit got = 1'b0;
    int n;
    if (!p) begin m0_we = we; m0_addr = a; m0_wdata = d; m0_wtag = t; m0_req = 1'b1; end
    else    begin m1_we = we; m1_addr = a; m1_wdata = d; m1_wtag = t; m1_req = 1'b1; end
    for (n = 1; n <= 10 && !got; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        chk("addr_astb", 64'(o_astb), 64'd1);
        chk("addr_ad", o_ad, {44'h0, a});
        chk("addr_tag", 64'(o_tag), 64'd0);
      end
      if (n == 2) begin
        if (we) begin
          chk("wr_strobe", 64'(o_wr), 64'd1);
          chk("wr_ad", o_ad, d);
          chk("wr_tag", 64'(o_tag), 64'(t));
        end else begin
          chk("rd_strobe", 64'(o_rd), 64'd1);
          chk("rd_ad", o_ad, 64'd0);
        end
      end
      if (m0_ack || m1_ack) begin
        got = 1'b1;
        chk("ack_latency", 64'(n), we ? 64'd3 : 64'd4);
        chk("ack_port", 64'(m1_ack), 64'(p));
        if (!we) begin
          exp_rd[p] = ed;
          exp_rt[p] = et;
        end else begin
          chk("ram_data", mem[a][63:0], d);
          chk("ram_tag", 64'(mem[a][71:64]), 64'(t));
        end
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m0_rtag", 64'(m0_rtag), 64'(exp_rt[0]));
        chk("m1_rdata", m1_rdata, exp_rd[1]);
        chk("m1_rtag", 64'(m1_rtag), 64'(exp_rt[1]));
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack within 10 cycles, required ack");
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [19:0] addr;
    logic [63:0] data;
    logic [7:0]  tag;
    logic [63:0] exp_d;
    logic [7:0]  exp_t;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int acks0, acks1, f_acks0, f_acks1_held, c;
    int ack_port [8];
    int ack_cyc  [8];
    int nack;

    vecs[0] = '{1'b0, 1'b1, 20'h00010, 64'h0123456789ABCDEF, 8'h35, 64'h0, 8'h0};
    vecs[1] = '{1'b1, 1'b0, 20'h00010, 64'h0, 8'h0, 64'h0123456789ABCDEF, 8'h35};
    vecs[2] = '{1'b1, 1'b1, 20'hFFFFF, 64'hDEADBEEFCAFEF00D, 8'hA5, 64'h0, 8'h0};
    vecs[3] = '{1'b0, 1'b0, 20'hFFFFF, 64'h0, 8'h0, 64'hDEADBEEFCAFEF00D, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 20'h00000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 8'h0};
    vecs[5] = '{1'b1, 1'b0, 20'h00000, 64'h0, 8'h0, 64'hFFFFFFFFFFFFFFFF, 8'hFF};
    vecs[6] = '{1'b0, 1'b0, 20'h00010, 64'h0, 8'h0, 64'h0123456789ABCDEF, 8'h35};

    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wtag = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wtag = '0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_rt[0] = '0; exp_rt[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", 64'({o_astb, o_rd, o_wr}), 64'd0);
    chk("rst_ad", o_ad, 64'd0);
    chk("rst_tag", 64'(o_tag), 64'd0);
    chk("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 64'd0);
    chk("rst_rtag", 64'({m0_rtag, m1_rtag}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_req", 64'({o_astb, o_rd, o_wr, m0_ack, m1_ack}), 64'd0);

    // directed table
    for (int i = 0; i < 7; i++)
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].tag,
          vecs[i].exp_d, vecs[i].exp_t);

    // both ports reading continuously from reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_rt[0] = '0; exp_rt[1] = '0;
    m0_we = 0; m0_addr = 20'h00010; m0_req = 1;
    m1_we = 0; m1_addr = 20'hFFFFF; m1_req = 1;
    acks0 = 0; acks1 = 0; f_acks0 = 0; f_acks1_held = 0; nack = 0;
    for (c = 1; c <= 60 && (m0_req || m1_req); c++) begin
      @(posedge clk); #1;
      if (f_m0_ack) f_acks0++;
      if (f_m1_ack && m0_req) f_acks1_held++;
      if ((m0_ack || m1_ack) && nack < 8) begin
        ack_port[nack] = m1_ack ? 1 : 0;
        ack_cyc[nack]  = c;
        nack++;
      end
      if (m0_ack) begin
        acks0++;
        chk("rr_m0_rdata", m0_rdata, 64'h0123456789ABCDEF);
        if (acks0 == 4) m0_req = 0;
      end
      if (m1_ack) begin
        acks1++;
        chk("rr_m1_rdata", m1_rdata, 64'hDEADBEEFCAFEF00D);
        if (acks1 == 4) m1_req = 0;
      end
    end
    m0_req = 0; m1_req = 0;
    chk("rr_ack_count", 64'(nack), 64'd8);
    for (int k = 0; k < 8 && k < nack; k++) begin
      chk("rr_grant_order", 64'(ack_port[k]), 64'(k % 2));
      chk("rr_ack_cycle", 64'(ack_cyc[k]), 64'(4 + 5 * k));
    end
    chk("fp_m0_acks", 64'(f_acks0), 64'd7);
    chk("fp_m1_while_m0_held", 64'(f_acks1_held), 64'd0);
    repeat (8) @(posedge clk);
    #1;

    // reset during READ
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_rt[0] = '0; exp_rt[1] = '0;
    m0_we = 0; m0_addr = 20'h00010; m0_req = 1;
    @(posedge clk); #1;
    chk("rst_rd_addr", 64'(o_astb), 64'd1);
    @(posedge clk); #1;
    chk("rst_rd_strobe", 64'(o_rd), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m0_req = 0;
    chk("midrst_bus", 64'({o_astb, o_rd, o_wr}), 64'd0);
    chk("midrst_ad", o_ad, 64'd0);
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack || o_astb || o_rd || o_wr) nack++;
    end
    chk("midrst_no_ack", 64'(nack), 64'd0);
    chk("midrst_rdata", m0_rdata, 64'd0);
    txn(1'b0, 1'b0, 20'h00010, 64'h0, 8'h0, 64'h0123456789ABCDEF, 8'h35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
